// File: rtl/picosoc_pkg.sv
// Shared definitions for the PicoSoC memory-bus arbiter slice: FSM state
// encoding, requester indices, bus widths, the default timeout read pattern
// and the packed request payload carried from a master to the slave port.
package picosoc_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Arbiter FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Requester indices
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam logic [DATA_W-1:0] DEFAULT_TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Request payload presented by a master and forwarded to the slave
  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // One-hot grant vector for a requester index
  function automatic logic [1:0] grant_onehot(input logic owner);
    return (owner == REQ_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/picosoc_bus_watchdog.sv
// Bus watchdog for the memory arbiter. Counts BUSY cycles without slave
// completion and flags expiry on the TIMEOUT_CYCLES-th such cycle; a value of
// 0 disables it. Latches the address and owner of the last timed-out access.
//   clk, resetn    : clock, async active-low reset
//   busy           : arbiter is in BUSY (counter clears whenever low)
//   owner_valid    : current owner still holds its request
//   s_ready        : slave completion (wins over a coinciding expiry)
//   owner, addr    : current owner index and its address
//   expire         : combinational expiry strobe for this cycle
//   timeout_addr   : address of the last timed-out transaction
//   timeout_owner  : requester index of the last timeout
module picosoc_bus_watchdog
  import picosoc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              busy,
  input  logic              owner_valid,
  input  logic              s_ready,
  input  logic              owner,
  input  logic [ADDR_W-1:0] addr,
  output logic              expire,
  output logic [ADDR_W-1:0] timeout_addr,
  output logic              timeout_owner
);

  localparam bit          ENABLE = (TIMEOUT_CYCLES != 0);
  // Counter only needs to reach TIMEOUT_CYCLES-1: it holds the number of
  // stalled BUSY cycles already elapsed, so the current cycle is count+1.
  localparam int unsigned CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  assign expire = ENABLE && busy && owner_valid && !s_ready && (count_q == LAST);

  // Stall counter; cleared outside BUSY so each transaction starts at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (!busy || !ENABLE) begin
      count_q <= '0;
    end else if (!s_ready) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Record of the most recent timeout
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_addr  <= '0;
      timeout_owner <= REQ_CPU;
    end else if (expire) begin
      timeout_addr  <= addr;
      timeout_owner <= owner;
    end
  end

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Two-requester arbiter for the PicoSoC native memory bus. m0 (CPU) and m1
// (DMA/debug) share one slave port. Round-robin between simultaneous
// requests, the winner owns the bus until completion, and a watchdog
// completes hung transactions with TIMEOUT_RDATA and an interrupt pulse.
//   clk, resetn              : clock, async active-low reset
//   mX_valid/instr/addr/
//   wdata/wstrb              : requester X native bus request
//   mX_ready, mX_rdata       : completion pulse and read data to requester X
//   s_valid/instr/addr/
//   wdata/wstrb              : request to the shared slave
//   s_ready, s_rdata         : slave completion and read data
//   grant                    : one-hot current owner, 0 when idle
//   timeout_irq              : one-cycle watchdog expiry pulse
//   timeout_addr/owner       : details of the last timed-out transaction
module picosoc_mem_arbiter
  import picosoc_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA,
  parameter bit                 M0_FIRST       = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_irq,
  output logic [ADDR_W-1:0] timeout_addr,
  output logic              timeout_owner
);

  // The pointer stores the last winner; the other requester wins a tie.
  localparam logic LAST_RST = M0_FIRST ? REQ_AUX : REQ_CPU;

  logic [0:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q,  last_d;

  mem_req_t    m0_req, m1_req, own_req, s_req;
  logic        own_valid;
  logic        wd_expire;
  logic        done;
  logic [DATA_W-1:0] done_rdata;

  assign m0_req = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  // Owner-side view of the request
  assign own_req   = (owner_q == REQ_AUX) ? m1_req   : m0_req;
  assign own_valid = (owner_q == REQ_AUX) ? m1_valid : m0_valid;

  assign s_instr = s_req.instr;
  assign s_addr  = s_req.addr;
  assign s_wdata = s_req.wdata;
  assign s_wstrb = s_req.wstrb;

  assign timeout_irq = wd_expire;

  picosoc_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk           (clk),
    .resetn        (resetn),
    .busy          (state_q == ST_BUSY),
    .owner_valid   (own_valid),
    .s_ready       (s_ready),
    .owner         (owner_q),
    .addr          (own_req.addr),
    .expire        (wd_expire),
    .timeout_addr  (timeout_addr),
    .timeout_owner (timeout_owner)
  );

  // State, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_CPU;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state, slave muxing and completion routing
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    s_valid    = 1'b0;
    s_req      = '0;
    grant      = 2'b00;
    done       = 1'b0;
    done_rdata = '0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;

    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = ST_BUSY;
          if (m0_valid && m1_valid) begin
            owner_d = ~last_q;
          end else begin
            owner_d = m1_valid ? REQ_AUX : REQ_CPU;
          end
        end
      end

      ST_BUSY: begin
        grant   = grant_onehot(owner_q);
        s_req   = own_req;
        s_valid = own_valid && !wd_expire;
        if (own_valid && s_ready) begin
          done       = 1'b1;
          done_rdata = s_rdata;
          last_d     = owner_q;
          state_d    = ST_IDLE;
        end else if (wd_expire) begin
          done       = 1'b1;
          done_rdata = TIMEOUT_RDATA;
          last_d     = owner_q;
          state_d    = ST_IDLE;
        end else if (!own_valid) begin
          // Owner withdrew without completion: abandon, pointer untouched
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      if (owner_q == REQ_AUX) begin
        m1_ready = 1'b1;
        m1_rdata = done_rdata;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = done_rdata;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Self-checking bench for picosoc_mem_arbiter (TIMEOUT_CYCLES=16): directed
// scenarios followed by random traffic, all checked cycle by cycle against a
// transaction-level reference model.
module tb_picosoc_mem_arbiter;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        mv [2];
  logic        mi [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_irq, timeout_owner;
  logic [31:0] timeout_addr;

  picosoc_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]),
    .m0_wstrb(ms[0]), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]),
    .m1_wstrb(ms[1]), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_irq(timeout_irq), .timeout_addr(timeout_addr),
    .timeout_owner(timeout_owner)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: is a transaction open, who owns it, how many stalled
  // BUSY cycles it has accumulated, who won last, and the last timeout.
  bit          busy_m;
  int          own_m, last_m, age_m, towner_m;
  logic [31:0] taddr_m;
  // Expected outputs for the current cycle
  bit          e_sv, e_irq, e_ok, e_tmo;
  bit          e_rdy [2];
  logic [31:0] e_rd  [2];
  logic [1:0]  e_grant;
  // Slave and master behaviour knobs
  int          cfg_wait, wait_left;
  bit          never, rand_slave, auto_mode;
  int          repeat_pct, start_pct;
  logic [31:0] slv_data;
  int          done_q [$];
  int          model_done, dut_done;
  // DUT snapshot taken at the checking point
  logic        obs_sv, obs_irq, obs_towner;
  logic        obs_r [2];
  logic [31:0] obs_rd [2];
  logic [31:0] obs_wdata, obs_taddr;
  logic [3:0]  obs_wstrb;
  logic [1:0]  obs_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_m = 0; own_m = 0; last_m = 1; age_m = 0;
    taddr_m = 32'h0; towner_m = 0;
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1;
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = 4'($urandom_range(15));
    mi[i] = 1'($urandom_range(1));
  endtask

  task automatic predict();
    bit ov;
    e_sv = 0; e_irq = 0; e_ok = 0; e_tmo = 0; e_grant = 2'b00;
    e_rdy[0] = 0; e_rdy[1] = 0; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
    if (busy_m) begin
      ov    = mv[own_m];
      e_ok  = ov && s_ready;
      e_tmo = ov && !s_ready && (age_m + 1 == TMO);
      e_grant = (own_m == 1) ? 2'b10 : 2'b01;
      e_sv  = ov && !e_tmo;
      e_irq = e_tmo;
      e_rdy[own_m] = e_ok || e_tmo;
      e_rd[own_m]  = e_ok ? s_rdata : (e_tmo ? 32'hFFFF_FFFF : 32'h0);
    end
  endtask

  task automatic compare();
    obs_sv = s_valid; obs_irq = timeout_irq; obs_grant = grant;
    obs_r[0] = m0_ready; obs_r[1] = m1_ready;
    obs_rd[0] = m0_rdata; obs_rd[1] = m1_rdata;
    obs_wdata = s_wdata; obs_wstrb = s_wstrb;
    obs_taddr = timeout_addr; obs_towner = timeout_owner;
    chk("s_valid", s_valid, e_sv);
    chk("grant", grant, e_grant);
    chk("m0_ready", m0_ready, e_rdy[0]);
    chk("m1_ready", m1_ready, e_rdy[1]);
    chk("m0_rdata", m0_rdata, e_rd[0]);
    chk("m1_rdata", m1_rdata, e_rd[1]);
    chk("timeout_irq", timeout_irq, e_irq);
    chk("timeout_addr", timeout_addr, taddr_m);
    chk("timeout_owner", timeout_owner, towner_m);
    if (e_sv) begin
      chk("s_addr", s_addr, ma[own_m]);
      chk("s_wdata", s_wdata, mw[own_m]);
      chk("s_wstrb", s_wstrb, ms[own_m]);
      chk("s_instr", s_instr, mi[own_m]);
    end
    if (m0_ready || m1_ready) dut_done++;
  endtask

  task automatic advance();
    if (!busy_m) begin
      if (mv[0] || mv[1]) begin
        busy_m = 1;
        own_m  = (mv[0] && mv[1]) ? 1 - last_m : (mv[0] ? 0 : 1);
        age_m  = 0;
        if (rand_slave) begin
          wait_left = $urandom_range(4);
          never     = ($urandom_range(19) == 0);
        end else begin
          wait_left = cfg_wait;
        end
      end
    end else if (e_ok || e_tmo) begin
      if (e_tmo) begin
        taddr_m  = ma[own_m];
        towner_m = own_m;
      end
      last_m = own_m;
      busy_m = 0;
      done_q.push_back(own_m);
      model_done++;
    end else if (!mv[own_m]) begin
      busy_m = 0;
    end else begin
      age_m++;
      if (wait_left > 0) wait_left--;
    end
  endtask

  task automatic masters_react();
    for (int i = 0; i < 2; i++) begin
      if (e_rdy[i]) begin
        if (auto_mode && $urandom_range(99) < repeat_pct) new_req(i);
        else mv[i] = 1'b0;
      end else if (auto_mode && !mv[i] && $urandom_range(99) < start_pct) begin
        new_req(i);
      end
    end
  endtask

  // One bus cycle: drive slave, check at negedge, advance model after posedge
  task automatic run_cycle();
    s_ready = busy_m && mv[own_m] && !never && (wait_left == 0);
    s_rdata = slv_data;
    @(negedge clk);
    predict();
    compare();
    @(posedge clk);
    advance();
    #1;
    masters_react();
    if (rand_slave) slv_data = $urandom;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    int idx;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = 32'h0; mw[i] = 32'h0; ms[i] = 4'h0;
    end
    s_ready = 1'b0; s_rdata = 32'h0;
    cfg_wait = 0; wait_left = 0; never = 0; rand_slave = 0; auto_mode = 0;
    repeat_pct = 0; start_pct = 0; slv_data = 32'h0;
    model_done = 0; dut_done = 0;
    model_reset();

    // Reset values, with a request pending to show it is ignored
    mv[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0_ready", m0_ready, 1'b0);
    chk("rst_irq", timeout_irq, 1'b0);
    chk("rst_taddr", timeout_addr, 32'h0);
    chk("rst_towner", timeout_owner, 1'b0);
    @(posedge clk); #1;
    mv[0] = 1'b0;
    resetn = 1'b1;

    // m0 zero-wait read
    mv[0] = 1'b1; ma[0] = 32'h0000_0100; ms[0] = 4'h0; mi[0] = 1'b0; mw[0] = 32'h0;
    slv_data = 32'h1234_5678; cfg_wait = 0;
    run_cycle();
    chk("t1_idle_sv", obs_sv, 1'b0);
    run_cycle();
    chk("t1_sv", obs_sv, 1'b1);
    chk("t1_ready", obs_r[0], 1'b1);
    chk("t1_rdata", obs_rd[0], 32'h1234_5678);
    chk("t1_m1_ready", obs_r[1], 1'b0);
    run_cycle();
    chk("t1_single_pulse", obs_r[0], 1'b0);

    // m1 write with three slave wait cycles
    mv[1] = 1'b1; ma[1] = 32'h0200_0010; mw[1] = 32'hCAFE_BABE; ms[1] = 4'b0011; mi[1] = 1'b0;
    cfg_wait = 3; idx = 0;
    for (int k = 1; k <= 12; k++) begin
      run_cycle();
      if (obs_r[1]) begin
        idx = k;
        chk("t3_wstrb", obs_wstrb, 4'b0011);
        chk("t3_wdata", obs_wdata, 32'hCAFE_BABE);
        break;
      end
    end
    chk("t3_ready_cycle", idx, 5);

    // Watchdog expiry on a hung m0 read
    mv[0] = 1'b1; ma[0] = 32'h0100_0004; ms[0] = 4'h0; never = 1; cfg_wait = 0; idx = 0;
    for (int k = 1; k <= 30; k++) begin
      run_cycle();
      if (obs_r[0]) begin
        idx = k;
        chk("t4_irq", obs_irq, 1'b1);
        chk("t4_rdata", obs_rd[0], 32'hFFFF_FFFF);
        chk("t4_sv_forced_low", obs_sv, 1'b0);
        break;
      end
    end
    chk("t4_expiry_cycle", idx, 17);
    never = 0;
    new_req(1);
    run_cycle();
    chk("t4_taddr", obs_taddr, 32'h0100_0004);
    chk("t4_towner", obs_towner, 1'b0);
    run_cycle();
    chk("t4_m1_granted", obs_grant, 2'b10);
    run_cycle();

    // Slave completion coinciding with the expiry cycle
    mv[0] = 1'b1; ma[0] = 32'h0000_0040; ms[0] = 4'h0; cfg_wait = 15;
    slv_data = 32'h5A5A_0F0F; idx = 0;
    for (int k = 1; k <= 30; k++) begin
      run_cycle();
      if (obs_r[0]) begin
        idx = k;
        chk("t5_irq", obs_irq, 1'b0);
        chk("t5_rdata", obs_rd[0], 32'h5A5A_0F0F);
        break;
      end
    end
    chk("t5_ready_cycle", idx, 17);
    run_cycle();
    chk("t5_taddr_kept", obs_taddr, 32'h0100_0004);

    // Reset while m1 waits on a stalled slave
    cfg_wait = 0; never = 1;
    new_req(1);
    repeat (4) run_cycle();
    resetn = 1'b0;
    #1;
    chk("t6_sv", s_valid, 1'b0);
    chk("t6_grant", grant, 2'b00);
    chk("t6_m1_ready", m1_ready, 1'b0);
    chk("t6_m1_rdata", m1_rdata, 32'h0);
    chk("t6_taddr", timeout_addr, 32'h0);
    model_reset();
    never = 0;
    new_req(0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_cycle();
    run_cycle();
    chk("t6_m0_first", obs_grant, 2'b01);
    repeat (4) run_cycle();

    // Continuous contention, zero wait: strict alternation
    do_reset();
    done_q.delete();
    auto_mode = 1; repeat_pct = 100; start_pct = 0; cfg_wait = 0;
    new_req(0); new_req(1);
    for (int k = 0; k < 40 && done_q.size() < 8; k++) run_cycle();
    chk("t2_count", done_q.size(), 8);
    for (int k = 0; k < done_q.size(); k++) chk("t2_order", done_q[k], k % 2);

    // Random traffic, random slave latency with occasional hangs
    do_reset();
    auto_mode = 1; rand_slave = 1; repeat_pct = 60; start_pct = 30;
    model_done = 0; dut_done = 0;
    repeat (3000) run_cycle();
    chk("rand_completions", dut_done, model_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picosoc_mem_arbiter.md
Name: picosoc_mem_arbiter

Overview:
- Two-requester arbiter for the PicoSoC native memory bus (valid/ready, addr, wdata, wstrb, rdata, instr).
- Shares one downstream slave port (iomem or RAM side) between the CPU (m0) and a secondary master such as DMA or debug (m1).
- Round-robin grant, transaction locking until ready, and a bus watchdog that completes hung transactions with an error pattern and raises an interrupt.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without s_ready before forced completion; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hFFFF_FFFF: rdata returned to the owner on timeout.
- M0_FIRST, 1: pointer reset value; 1 means m0 wins the first simultaneous request.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid, m1_valid  in  1  request valid, held until ready
- m0_instr, m1_instr  in  1  instruction-fetch flag
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  byte strobes; 0 means read
- m0_ready, m1_ready  out  1  completion pulse to requester
- m0_rdata, m1_rdata  out  32  read data
- s_valid  out  1  slave request
- s_instr  out  1  slave instr flag
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 0 when idle
- timeout_irq  out  1  one-cycle pulse on watchdog expiry
- timeout_addr  out  32  address of the last timed-out transaction
- timeout_owner  out  1  requester index of the last timeout

Behaviour:
- Reset (async, resetn=0): state IDLE, grant=0, all ready outputs 0, s_valid=0, timeout_irq=0, timeout_addr=0, timeout_owner=0, counter=0.
  - Pointer resets to m0 when M0_FIRST=1.
  - Reset mid-transaction aborts it silently; no ready is issued.
- State IDLE:
  - Outputs s_valid=0, grant=0.
  - If any mX_valid is high, register the owner and go to BUSY on the next edge.
  - Single request: that requester wins.
  - Both requesting: the requester not granted last wins (round-robin pointer).
- State BUSY:
  - s_valid = owner's valid.
  - s_addr/s_wdata/s_wstrb/s_instr are muxed combinationally from the owner.
  - The non-owner's signals are ignored.
- Completion:
  - owner_ready = s_ready combinationally; owner_rdata = s_rdata.
  - Non-owner ready=0, rdata=0.
  - On s_ready: pointer updates to the owner, state goes to IDLE.
  - s_valid is always low for at least one cycle between transactions, including back-to-back requests from the same master.
- Latency: request seen in IDLE at cycle N gives s_valid at N+1; a combinational slave completes at N+1, so the minimum is 2 cycles per transaction.
- Owner drops valid in BUSY without ready (illegal, tolerated): return to IDLE, no ready, pointer unchanged.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - At count == TIMEOUT_CYCLES: owner_ready=1 with rdata=TIMEOUT_RDATA, s_valid forced 0 that cycle, timeout_irq=1.
  - Same cycle: latch timeout_addr and timeout_owner; state goes to IDLE and the pointer updates.
  - If s_ready and expiry coincide, s_ready wins: normal completion, no irq.
- Writes: wstrb is passed unchanged. The arbiter never modifies data or address width.
- The non-owner must see ready=0 in every cycle. Its valid may stay high indefinitely while it waits.

Decomposition:
- Shared package picosoc_pkg holds:
  - state encoding (IDLE, BUSY)
  - requester index constants (REQ_CPU=0, REQ_AUX=1)
  - default TIMEOUT_RDATA constant
- One sub-module, picosoc_bus_watchdog: counter, expiry compare, disable on TIMEOUT_CYCLES=0, latched timeout_addr/timeout_owner.
- Grant logic and muxing stay in the top module.

Test Plan:
- m0 read at 0x0000_0100, slave returns 0x1234_5678 with zero wait → s_valid 1 cycle after m0_valid; m0_ready pulses once with rdata 0x1234_5678; m1_ready stays 0.
- m0 and m1 both request continuously, slave zero wait → grants alternate m0,m1,m0,m1 with one idle s_valid cycle between each; 8 transactions, 4 each.
- m1 write 0xCAFEBABE, wstrb 4'b0011, addr 0x0200_0010, slave ready after 3 wait cycles → s_wstrb=0011 and s_wdata intact on the slave; m1_ready asserted exactly at the slave's ready cycle.
- TIMEOUT_CYCLES=16, slave never ready, m0 read at 0x0100_0004 → m0_ready and timeout_irq at the 16th BUSY cycle, rdata 0xFFFF_FFFF, timeout_addr=0x0100_0004, timeout_owner=0; next m1 request is granted.
- s_ready coinciding with watchdog expiry → normal completion with slave rdata, timeout_irq stays 0.
- resetn asserted in BUSY while m1 is waiting on the slave → all outputs 0 immediately; after release m0 wins the first contested grant.
